pot_ramp_ctrl: RTL and testbench

POT_RAMP_CTRL -- requirements
Module: pot_ramp_ctrl

---
 rtl/pot_ramp_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pot_ramp_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_ramp_ctrl.sv
// Wiper ramp controller for a DS3502 digital pot: steps the wiper toward a target through an I2C writer.
// Optional stepwise ramp enabled by defining POT_RAMP_STEP_EN; otherwise each target is one direct write.
module pot_ramp_ctrl #(
    parameter int         STEP         = 1,
    parameter int         DWELL_CYCLES = 3400,
    parameter int         ACK_TIMEOUT  = 64,
    parameter logic [7:0] INIT_VAL     = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_data,
    output logic       tgt_ready,
    output logic [7:0] cur_val,
    output logic       at_target,
    output logic       pot_load,
    output logic [7:0] pot_r,
    input  logic       pot_busy,
    output logic       err_timeout
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    if (STEP < 1 || STEP > 127) begin : g_bad_step
        $error("pot_ramp_ctrl: STEP must be 1..127");
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("pot_ramp_ctrl: DWELL_CYCLES must be at least 1");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack
        $error("pot_ramp_ctrl: ACK_TIMEOUT must be at least 1");
    end

`ifdef POT_RAMP_STEP_EN
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE, DWELL} state_t;
    localparam int         DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [7:0] STEP_V  = 8'(STEP);
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
`else
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       tgt_q, tgt_d;
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       next_q, next_d;
    logic [7:0]       pot_r_q, pot_r_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;

    // The device only accepts 0..127, so larger requests clamp to full scale.
    function automatic logic [7:0] sat_7f(input logic [7:0] v);
        return v[7] ? 8'h7F : v;
    endfunction

    function automatic logic [7:0] next_toward(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef POT_RAMP_STEP_EN
        logic [7:0] dist;
        logic [7:0] inc;
        dist = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        inc  = (dist < STEP_V) ? dist : STEP_V;
        return (tgt > cur) ? (cur + inc) : (cur - inc);
`else
        return (cur == tgt) ? cur : tgt;
`endif
    endfunction

`ifdef POT_RAMP_STEP_EN
    assign tgt_ready = (state_q == IDLE) || (state_q == DWELL);
`else
    assign tgt_ready = (state_q == IDLE);
`endif

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cur_d     = cur_q;
        next_d    = next_q;
        pot_r_d   = pot_r_q;
        load_d    = 1'b0;
        err_d     = err_q;
        ack_cnt_d = ack_cnt_q;
`ifdef POT_RAMP_STEP_EN
        dwell_cnt_d = dwell_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = sat_7f(tgt_data);
                    err_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (tgt_q == cur_q) begin
                    state_d = IDLE;
                end else begin
                    next_d  = next_toward(cur_q, tgt_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!pot_busy) begin
                    load_d    = 1'b1;
                    pot_r_d   = next_q;
                    ack_cnt_d = '0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (pot_busy) begin
                    ack_cnt_d = '0;
                    state_d   = WAIT_DONE;
                end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    ack_cnt_d = '0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!pot_busy) begin
                    cur_d = next_q;
`ifdef POT_RAMP_STEP_EN
                    state_d = (next_q == tgt_q) ? IDLE : DWELL;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef POT_RAMP_STEP_EN
            // A fresh target abandons the dwell; the next step starts from cur_q, so reversal cannot overshoot.
            DWELL: begin
                if (tgt_valid) begin
                    tgt_d       = sat_7f(tgt_data);
                    err_d       = 1'b0;
                    dwell_cnt_d = '0;
                    state_d     = CALC;
                end else if (dwell_cnt_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                    dwell_cnt_d = '0;
                    state_d     = CALC;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tgt_q     <= INIT_VAL;
            cur_q     <= INIT_VAL;
            next_q    <= INIT_VAL;
            pot_r_q   <= INIT_VAL;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_cnt_q <= '0;
`ifdef POT_RAMP_STEP_EN
            dwell_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
            next_q    <= next_d;
            pot_r_q   <= pot_r_d;
            load_q    <= load_d;
            err_q     <= err_d;
            ack_cnt_q <= ack_cnt_d;
`ifdef POT_RAMP_STEP_EN
            dwell_cnt_q <= dwell_cnt_d;
`endif
        end
    end

    assign cur_val     = cur_q;
    assign pot_r       = pot_r_q;
    assign pot_load    = load_q;
    assign err_timeout = err_q;
    assign at_target   = (state_q == IDLE) && (cur_q == tgt_q);

endmodule

// File: tb/tb_pot_ramp_ctrl.sv
// Scoreboard bench for pot_ramp_ctrl: expected wiper writes are queued by the stimulus, a monitor pops them on pot_load.
// Expectations follow the POT_RAMP_STEP_EN build setting.
module tb_pot_ramp_ctrl;
    localparam int DW = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_data = 8'h00;
    logic       tgt_ready;
    logic [7:0] cur_val;
    logic       at_target;
    logic       pot_load;
    logic [7:0] pot_r;
    logic       pot_busy;
    logic       err_timeout;

    logic busy_w = 1'b0;
    logic busy_hold = 1'b0;
    logic ack_en = 1'b1;
    assign pot_busy = busy_w | busy_hold;

    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    bit         chk_space = 1'b0;
    int         last_load = -1;
    bit         prev_load = 1'b0;

    pot_ramp_ctrl #(
        .STEP(1), .DWELL_CYCLES(DW), .ACK_TIMEOUT(64), .INIT_VAL(8'h40)
    ) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(tgt_ready), .cur_val(cur_val), .at_target(at_target),
        .pot_load(pot_load), .pot_r(pot_r), .pot_busy(pot_busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_ge(input string nm, input int act, input int lim);
        n_checks++;
        if (act < lim) begin
            n_err++;
            $display("FAIL %s: got %0d expected at least %0d", nm, act, lim);
        end
    endtask

    task automatic expect_w(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    // Writer model: acknowledges a load one cycle later and stays busy for three cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && pot_load && ack_en) begin
                busy_w = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                busy_w = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (pot_load) begin
            check("load_gap", int'(prev_load), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_load: got pot_r=0x%0h expected no write", pot_r);
            end else begin
                check("pot_r", int'(pot_r), int'(exp_q.pop_front()));
            end
            if (chk_space && last_load >= 0)
                check_ge("load_spacing", cyc - last_load, DW);
            last_load = cyc;
        end
        prev_load = pot_load;
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        check("tgt_ready", int'(tgt_ready), 1);
        tgt_valid = 1'b1;
        tgt_data  = d;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (at_target && tgt_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle: got no at_target expected it within %0d cycles", max);
        end
    endtask

    task automatic wait_load(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (pot_load) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_load: got no pot_load expected one within %0d cycles", max);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int t0;
        int dt;
        bit seen;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cur_val", int'(cur_val), 'h40);
        check("rst_pot_r", int'(pot_r), 'h40);
        check("rst_pot_load", int'(pot_load), 0);
        check("rst_at_target", int'(at_target), 1);
        check("rst_err", int'(err_timeout), 0);
        check("rst_ready", int'(tgt_ready), 1);
        rst = 1'b1;

        // target equal to current value: no write
        send(8'h40);
        repeat (5) @(negedge clk);
        check("same_at_target", int'(at_target), 1);
        check("same_cur_val", int'(cur_val), 'h40);

        // ramp 40 -> 44
`ifdef POT_RAMP_STEP_EN
        expect_w(8'h41); expect_w(8'h42); expect_w(8'h43); expect_w(8'h44);
`else
        expect_w(8'h44);
`endif
        chk_space = 1'b1;
        last_load = -1;
        send(8'h44);
        wait_idle(500);
        chk_space = 1'b0;
        check("ramp44_cur_val", int'(cur_val), 'h44);
        check("ramp44_pot_r_hold", int'(pot_r), 'h44);
        check("ramp44_pending", exp_q.size(), 0);

        // saturating target, plus a target offered while busy (must be dropped)
`ifdef POT_RAMP_STEP_EN
        for (int v = 'h45; v <= 'h7F; v++) expect_w(8'(v));
`else
        expect_w(8'h7F);
`endif
        send(8'hFF);
        wait_load(100);
        @(negedge clk);
        check("busy_ready_low", int'(tgt_ready), 0);
        tgt_valid = 1'b1;
        tgt_data  = 8'h00;
        @(negedge clk);
        tgt_valid = 1'b0;
        wait_idle(4000);
        check("sat_cur_val", int'(cur_val), 'h7F);
        check("sat_pending", exp_q.size(), 0);

        // retarget in the middle of a ramp reverses direction without overshoot
        do_reset();
        check("rst2_cur_val", int'(cur_val), 'h40);
`ifdef POT_RAMP_STEP_EN
        expect_w(8'h41); expect_w(8'h42); expect_w(8'h43);
        expect_w(8'h42); expect_w(8'h41); expect_w(8'h40); expect_w(8'h3F); expect_w(8'h3E);
        send(8'h50);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cur_val == 8'h43) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach_43", int'(seen), 1);
        send(8'h3E);
        wait_idle(500);
`else
        expect_w(8'h50); expect_w(8'h3E);
        send(8'h50);
        wait_idle(500);
        send(8'h3E);
        wait_idle(500);
`endif
        check("rev_cur_val", int'(cur_val), 'h3E);
        check("rev_pending", exp_q.size(), 0);

        // writer never acknowledges
        ack_en = 1'b0;
`ifdef POT_RAMP_STEP_EN
        expect_w(8'h3F);
`else
        expect_w(8'h45);
`endif
        send(8'h45);
        wait_load(50);
        t0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        dt = cyc - t0;
        check("timeout_seen", int'(seen), 1);
        check("timeout_cycles", dt, 64);
        check("timeout_cur_val", int'(cur_val), 'h3E);
        check("timeout_at_target", int'(at_target), 0);
        check("timeout_ready", int'(tgt_ready), 1);
        ack_en = 1'b1;
        send(8'h3E);
        @(negedge clk);
        check("err_cleared", int'(err_timeout), 0);
        check("clear_at_target", int'(at_target), 1);

        // after reset the write holds in ISSUE while the writer is still busy
        busy_hold = 1'b1;
        do_reset();
`ifdef POT_RAMP_STEP_EN
        expect_w(8'h41); expect_w(8'h42);
        send(8'h42);
        repeat (20) @(negedge clk);
        check("held_pending", exp_q.size(), 2);
`else
        expect_w(8'h42);
        send(8'h42);
        repeat (20) @(negedge clk);
        check("held_pending", exp_q.size(), 1);
`endif
        busy_hold = 1'b0;
        wait_idle(300);
        check("held_cur_val", int'(cur_val), 'h42);
        check("held_pending_done", exp_q.size(), 0);

        // asynchronous reset while the write is in progress
`ifdef POT_RAMP_STEP_EN
        expect_w(8'h43);
`else
        expect_w(8'h44);
`endif
        send(8'h44);
        wait_load(50);
        @(negedge clk);
        check("mid_write_ready", int'(tgt_ready), 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_pot_load", int'(pot_load), 0);
        check("async_cur_val", int'(cur_val), 'h40);
        check("async_at_target", int'(at_target), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_cur_val", int'(cur_val), 'h40);
        check("post_rst_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
